// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one synchronous-read memory port.
// Grant/stall are combinational; read data returns one cycle after the grant.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stallf_o,
  output logic              stallm_o,
  output logic [31:0]       if_conflict_cnt_o,
  output logic [31:0]       dm_conflict_cnt_o
);

  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_e;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  logic [3:0]        streak_q, streak_d;
  owner_e            owner_q, owner_d;
  logic              is_store_q, is_store_d;
  logic [DATA_W-1:0] if_hold_q, dm_hold_q;
  logic [31:0]       if_cnt_q, if_cnt_d, dm_cnt_q, dm_cnt_d;
  logic              if_grant, dm_grant, dm_load_vld;

  // Data has priority until it has starved a waiting fetch MAX_D_STREAK times.
  assign if_grant = ~reset & if_req_i & (~dm_req_i | (streak_q == STREAK_MAX));
  assign dm_grant = ~reset & dm_req_i & ~if_grant;

  assign mem_en_o    = if_grant | dm_grant;
  assign mem_we_o    = dm_grant & dm_we_i;
  assign mem_addr_o  = if_grant ? if_addr_i : dm_addr_i;
  assign mem_wdata_o = dm_wdata_i;

  assign stallf_o = ~reset & if_req_i & ~if_grant;
  assign stallm_o = ~reset & dm_req_i & ~dm_grant;

  // Masking with reset drops the return of a grant made just before reset.
  assign if_valid_o  = ~reset & (owner_q == OWN_IF);
  assign dm_valid_o  = ~reset & (owner_q == OWN_DM);
  assign dm_load_vld = dm_valid_o & ~is_store_q;

  assign if_rdata_o = reset ? '0 : (if_valid_o  ? mem_rdata_i : if_hold_q);
  assign dm_rdata_o = reset ? '0 : (dm_load_vld ? mem_rdata_i : dm_hold_q);

  assign if_conflict_cnt_o = if_cnt_q;
  assign dm_conflict_cnt_o = dm_cnt_q;

  always_comb begin
    streak_d   = streak_q;
    owner_d    = OWN_NONE;
    is_store_d = 1'b0;
    if (if_grant || !if_req_i) begin
      streak_d = '0;
    end else if (dm_grant) begin
      streak_d = streak_q + 4'd1;
    end
    if (if_grant) begin
      owner_d = OWN_IF;
    end else if (dm_grant) begin
      owner_d    = OWN_DM;
      is_store_d = dm_we_i;
    end
    if_cnt_d = (stallf_o && (if_cnt_q != '1)) ? if_cnt_q + 32'd1 : if_cnt_q;
    dm_cnt_d = (stallm_o && (dm_cnt_q != '1)) ? dm_cnt_q + 32'd1 : dm_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q   <= '0;
      owner_q    <= OWN_NONE;
      is_store_q <= 1'b0;
      if_hold_q  <= '0;
      dm_hold_q  <= '0;
      if_cnt_q   <= '0;
      dm_cnt_q   <= '0;
    end else begin
      streak_q   <= streak_d;
      owner_q    <= owner_d;
      is_store_q <= is_store_d;
      if_cnt_q   <= if_cnt_d;
      dm_cnt_q   <= dm_cnt_d;
      if (if_valid_o) begin
        if_hold_q <= mem_rdata_i;
      end
      if (dm_load_vld) begin
        dm_hold_q <= mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a transaction-level model.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0;
  logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0, mem_rdata_i = '0;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
  logic [31:0] if_conflict_cnt_o, dm_conflict_cnt_o;
  logic        if_valid_o, dm_valid_o, mem_en_o, mem_we_o, stallf_o, stallm_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .stallf_o(stallf_o), .stallm_o(stallm_o),
    .if_conflict_cnt_o(if_conflict_cnt_o), .dm_conflict_cnt_o(dm_conflict_cnt_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural memory: reads registered, unread cycles return garbage.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (mem_en_o && !mem_we_o) mem_rdata_i <= memval(mem_addr_o);
    else                       mem_rdata_i <= $urandom;
    if (mem_en_o && mem_we_o) mem[mem_addr_o] = mem_wdata_o;
  end

  // Reference model: transaction state as plain integers.
  int          m_streak = 0;
  int          m_pend = 0;          // 0 none, 1 fetch, 2 load, 3 store
  logic [31:0] m_pdata = '0, m_ifh = '0, m_dmh = '0, m_cif = '0, m_cdm = '0;

  logic        exp_en, exp_we, exp_sf, exp_sm, exp_ifv, exp_dmv;
  logic [31:0] exp_addr, exp_wdata, exp_ifd, exp_dmd, exp_cif, exp_cdm;
  logic        obs_en, obs_we, obs_sf, obs_sm, obs_ifv, obs_dmv;
  logic [31:0] obs_addr, obs_wdata, obs_ifd, obs_dmd, obs_cif, obs_cdm;

  task automatic step(input logic rst_v, input logic ifr, input logic [31:0] ifa,
                      input logic dmr, input logic dmwe, input logic [31:0] dma,
                      input logic [31:0] dmwd);
    int eg;
    @(negedge clk);
    reset = rst_v; if_req_i = ifr; if_addr_i = ifa;
    dm_req_i = dmr; dm_we_i = dmwe; dm_addr_i = dma; dm_wdata_i = dmwd;
    if (rst_v)            eg = 0;
    else if (ifr && dmr)  eg = (m_streak == MAXS) ? 1 : 2;
    else if (ifr)         eg = 1;
    else if (dmr)         eg = 2;
    else                  eg = 0;
    exp_en    = (eg != 0);
    exp_we    = (eg == 2) && dmwe;
    exp_addr  = (eg == 1) ? ifa : dma;
    exp_wdata = dmwd;
    exp_sf    = !rst_v && ifr && (eg != 1);
    exp_sm    = !rst_v && dmr && (eg != 2);
    exp_ifv   = !rst_v && (m_pend == 1);
    exp_dmv   = !rst_v && (m_pend >= 2);
    exp_ifd   = rst_v ? 32'h0 : (exp_ifv ? m_pdata : m_ifh);
    exp_dmd   = rst_v ? 32'h0 : ((m_pend == 2) ? m_pdata : m_dmh);
    exp_cif   = m_cif;
    exp_cdm   = m_cdm;
    #2;
    obs_en = mem_en_o; obs_we = mem_we_o; obs_addr = mem_addr_o; obs_wdata = mem_wdata_o;
    obs_sf = stallf_o; obs_sm = stallm_o; obs_ifv = if_valid_o; obs_dmv = dm_valid_o;
    obs_ifd = if_rdata_o; obs_dmd = dm_rdata_o;
    obs_cif = if_conflict_cnt_o; obs_cdm = dm_conflict_cnt_o;
    if (rst_v) begin
      m_streak = 0; m_pend = 0; m_ifh = '0; m_dmh = '0; m_cif = '0; m_cdm = '0;
    end else begin
      m_ifh = exp_ifd;
      m_dmh = exp_dmd;
      if (exp_sf && m_cif != 32'hFFFF_FFFF) m_cif = m_cif + 1;
      if (exp_sm && m_cdm != 32'hFFFF_FFFF) m_cdm = m_cdm + 1;
      if (eg == 1 || !ifr) m_streak = 0;
      else if (eg == 2)    m_streak = m_streak + 1;
      m_pend  = (eg == 0) ? 0 : (eg == 1) ? 1 : (dmwe ? 3 : 2);
      m_pdata = memval(exp_addr);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 32'h5);
      checks++;
      if (obs_en !== 1'b0 || obs_we !== 1'b0) begin
        errors++; $display("FAIL reset_mem_en: got en=%b we=%b want 0/0", obs_en, obs_we);
      end
      checks++;
      if (obs_sf !== 1'b0 || obs_sm !== 1'b0) begin
        errors++; $display("FAIL reset_stall: got %b%b want 00", obs_sf, obs_sm);
      end
      checks++;
      if (obs_ifv !== 1'b0 || obs_dmv !== 1'b0) begin
        errors++; $display("FAIL reset_valid: got %b%b want 00", obs_ifv, obs_dmv);
      end
    end
    checks++;
    if (obs_cif !== 32'h0 || obs_cdm !== 32'h0) begin
      errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", obs_cif, obs_cdm);
    end
  endtask

  task automatic test_if_only();
    logic [31:0] want [3];
    want[0] = 32'h0050_0113; want[1] = 32'h00A0_0193; want[2] = 32'h0031_00B3;
    mem[32'h0] = want[0]; mem[32'h4] = want[1]; mem[32'h8] = want[2];
    for (int i = 0; i < 4; i++) begin
      if (i < 3) step(1'b0, 1'b1, 32'(i * 4), 1'b0, 1'b0, 32'h0, 32'h0);
      else       idle();
      if (i > 0) begin
        checks++;
        if (obs_ifv !== 1'b1 || obs_ifd !== want[i-1]) begin
          errors++; $display("FAIL if_only_data[%0d]: got v=%b %h want 1 %h", i, obs_ifv, obs_ifd, want[i-1]);
        end
      end
      checks++;
      if (obs_sf !== 1'b0) begin
        errors++; $display("FAIL if_only_stall[%0d]: got %b want 0", i, obs_sf);
      end
    end
    checks++;
    if (obs_cif !== 32'h0) begin
      errors++; $display("FAIL if_only_cnt: got %0d want 0", obs_cif);
    end
  endtask

  task automatic test_store();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h2024, 32'h59);
    checks++;
    if (obs_en !== 1'b1 || obs_we !== 1'b1 || obs_addr !== 32'h2024 || obs_wdata !== 32'h59) begin
      errors++; $display("FAIL store_port: got en=%b we=%b %h/%h want 1 1 2024/59", obs_en, obs_we, obs_addr, obs_wdata);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h2024, 32'h0);
    checks++;
    if (obs_dmv !== 1'b1 || obs_ifv !== 1'b0 || obs_dmd !== exp_dmd) begin
      errors++; $display("FAIL store_ack: got v=%b iv=%b d=%h want 1 0 %h", obs_dmv, obs_ifv, obs_dmd, exp_dmd);
    end
    idle();
    checks++;
    if (obs_dmv !== 1'b1 || obs_dmd !== 32'h59) begin
      errors++; $display("FAIL store_readback: got v=%b %h want 1 00000059", obs_dmv, obs_dmd);
    end
  endtask

  task automatic test_contention();
    logic [31:0] c_if0, c_dm0;
    idle();
    c_if0 = obs_cif; c_dm0 = obs_cdm;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h3000, 32'h0);
      if (i == 0) begin c_if0 = obs_cif; c_dm0 = obs_cdm; end
      checks++;
      if (obs_en !== 1'b1 || obs_addr !== ((i == 4 || i == 9) ? 32'h1000 : 32'h3000)) begin
        errors++; $display("FAIL contention_grant[%0d]: got en=%b addr=%h", i, obs_en, obs_addr);
      end
    end
    idle();
    checks++;
    if (obs_cif - c_if0 !== 32'd8 || obs_cdm - c_dm0 !== 32'd2) begin
      errors++; $display("FAIL contention_cnt: got %0d/%0d want 8/2", obs_cif - c_if0, obs_cdm - c_dm0);
    end
  endtask

  task automatic test_load_vs_fetch();
    mem[32'h100] = 32'hABCD_E02E;
    idle();
    step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 32'h100, 32'h0);
    checks++;
    if (obs_sf !== 1'b1 || obs_sm !== 1'b0 || obs_addr !== 32'h100) begin
      errors++; $display("FAIL lvf_arb: got sf=%b sm=%b addr=%h want 1 0 100", obs_sf, obs_sm, obs_addr);
    end
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (obs_dmv !== 1'b1 || obs_dmd !== 32'hABCD_E02E) begin
      errors++; $display("FAIL lvf_load: got v=%b %h want 1 abcde02e", obs_dmv, obs_dmd);
    end
    checks++;
    if (obs_sf !== 1'b0 || obs_addr !== 32'h200) begin
      errors++; $display("FAIL lvf_fetch_grant: got sf=%b addr=%h want 0 200", obs_sf, obs_addr);
    end
    idle();
    checks++;
    if (obs_ifv !== 1'b1 || obs_ifd !== memval(32'h200)) begin
      errors++; $display("FAIL lvf_fetch_data: got v=%b %h want 1 %h", obs_ifv, obs_ifd, memval(32'h200));
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'h8, 1'b1, 1'b0, 32'h10, 32'h0);
    checks++;
    if (obs_ifv !== 1'b0 || obs_en !== 1'b0 || obs_sf !== 1'b0 || obs_ifd !== 32'h0) begin
      errors++; $display("FAIL rstmid_cycle: got v=%b en=%b sf=%b d=%h want 0 0 0 0", obs_ifv, obs_en, obs_sf, obs_ifd);
    end
    idle();
    checks++;
    if (obs_ifv !== 1'b0 || obs_dmv !== 1'b0 || obs_ifd !== 32'h0 || obs_cif !== 32'h0 || obs_cdm !== 32'h0) begin
      errors++; $display("FAIL rstmid_after: got v=%b%b d=%h cnt=%0d/%0d want cleared", obs_ifv, obs_dmv, obs_ifd, obs_cif, obs_cdm);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 7, 32'($urandom_range(0, 15) * 4),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 32'($urandom_range(0, 15) * 4),
           $urandom);
      checks++;
      if (obs_en !== exp_en || obs_we !== exp_we || (exp_en && obs_addr !== exp_addr) ||
          (exp_we && obs_wdata !== exp_wdata)) begin
        errors++; $display("FAIL rand_port[%0d]: got %b%b %h %h want %b%b %h %h", i,
                           obs_en, obs_we, obs_addr, obs_wdata, exp_en, exp_we, exp_addr, exp_wdata);
      end
      checks++;
      if (obs_sf !== exp_sf || obs_sm !== exp_sm) begin
        errors++; $display("FAIL rand_stall[%0d]: got %b%b want %b%b", i, obs_sf, obs_sm, exp_sf, exp_sm);
      end
      checks++;
      if (obs_ifv !== exp_ifv || obs_dmv !== exp_dmv || obs_ifd !== exp_ifd || obs_dmd !== exp_dmd) begin
        errors++; $display("FAIL rand_ret[%0d]: got %b%b %h %h want %b%b %h %h", i,
                           obs_ifv, obs_dmv, obs_ifd, obs_dmd, exp_ifv, exp_dmv, exp_ifd, exp_dmd);
      end
      checks++;
      if (obs_cif !== exp_cif || obs_cdm !== exp_cdm) begin
        errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, obs_cif, obs_cdm, exp_cif, exp_cdm);
      end
    end
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_store();
    test_contention();
    test_load_vs_fetch();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the pipeline's instruction-fetch (IF) and data-memory (MEM) requesters onto one single-ported, synchronous-read unified memory. Each cycle it grants at most one requester, drives the memory port, routes the registered read data back to its owner, and raises per-stage stall requests into the hazard unit. Two saturating conflict counters let benches measure CPI loss from port contention.

## Interface
- ADDR_W, 32, memory address width (byte address)
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while IF is waiting; range 1..15
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- if_req_i  in  1  fetch request, held until served
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetch data, valid with if_valid_o
- if_valid_o  out  1  one-cycle pulse: fetch data returned
- dm_req_i  in  1  data request, held until served
- dm_we_i  in  1  1 = store, 0 = load
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  store data
- dm_rdata_o  out  DATA_W  load data, valid with dm_valid_o
- dm_valid_o  out  1  one-cycle pulse: load data returned or store acknowledged
- mem_en_o  out  1  memory access this cycle
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid the cycle after mem_en_o with mem_we_o=0
- stallf_o  out  1  to hazard unit: fetch not granted this cycle
- stallm_o  out  1  to hazard unit: data access not granted this cycle
- if_conflict_cnt_o  out  32  cycles with stallf_o=1, saturates at 0xFFFFFFFF
- dm_conflict_cnt_o  out  32  cycles with stallm_o=1, saturates at 0xFFFFFFFF

## Operation
- Grant (combinational, same cycle): only one requester -> it wins; both -> data wins unless streak counter == MAX_D_STREAK, then IF wins.
- Streak counter (4-bit): increments on a data grant while if_req_i=1; clears on any IF grant or any cycle with if_req_i=0; never exceeds MAX_D_STREAK.
- Memory port driven from winner: mem_en_o=1, mem_addr_o=winner address; mem_we_o=dm_we_i and mem_wdata_o=dm_wdata_i only for a data grant, else mem_we_o=0. No grant -> mem_en_o=0, mem_we_o=0, address/wdata don't-care.
- stallf_o = if_req_i & ~if_grant; stallm_o = dm_req_i & ~dm_grant. Both purely combinational.
- Return-path register: owner (NONE/IF/DM) and is_store registered on grant. Next cycle: owner IF -> if_valid_o=1, if_rdata_o=mem_rdata_i; owner DM load -> dm_valid_o=1, dm_rdata_o=mem_rdata_i; owner DM store -> dm_valid_o=1, dm_rdata_o unchanged.
- rdata outputs pass mem_rdata_i through while valid; hold last value otherwise.
- Back-to-back grants allowed every cycle; no pipeline bubble inserted by the arbiter.
- Conflict counters increment by 1 on each cycle their stall output is 1; hold at all-ones.

## Timing
- Grant, mem_* and stall outputs: 0-cycle latency from requests.
- Read latency: valid pulse exactly 1 cycle after grant cycle.
- Reset (synchronous, wins over all): streak=0, owner=NONE, if_valid_o=0, dm_valid_o=0, if_rdata_o=0, dm_rdata_o=0, both counters=0. During a reset cycle mem_en_o=0, mem_we_o=0, stallf_o=0, stallm_o=0 regardless of requests.
- Reset mid-operation: a grant issued in the cycle before reset produces no valid pulse.
- Request dropped after a stall (flush): no effect on state except streak rule; no valid pulse generated.
- Simultaneous requests at streak limit: IF granted, streak->0, data stalled exactly one cycle.
- MAX_D_STREAK=1 yields strict alternation under continuous contention.

## Test plan
- Reset: hold reset 2 cycles with both requests high -> mem_en_o=0, stalls 0, counters 0, no valid pulses.
- IF only: if_req_i=1, addr 0x0,0x4,0x8 on consecutive cycles, memory returns 0x00500113,... -> if_valid_o each following cycle with matching data, stallf_o=0, if_conflict_cnt_o=0.
- Data store: dm_req_i=1, dm_we_i=1, addr 0x2024, wdata 0x59, IF idle -> mem_we_o=1 same cycle with 0x2024/0x59, dm_valid_o pulse next cycle.
- Contention, MAX_D_STREAK=4: both requests held 10 cycles -> grant pattern D,D,D,D,I,D,D,D,D,I; if_conflict_cnt_o=8, dm_conflict_cnt_o=2.
- Load vs fetch: both request one cycle, data load at 0x100 returns 0xABCDE02E -> dm_valid_o with 0xABCDE02E next cycle, stallf_o=1 once, IF granted the following cycle.
- Reset mid-operation: grant IF load in cycle N, assert reset in N+1 -> if_valid_o stays 0, all state cleared.
